// File: rtl/twos_pkg.sv
// Shared types and helpers for the serial two's-complement to sign-magnitude decoder.
package twos_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // True when the low `width` bits of `word` are 1 followed by all zeros.
  function automatic logic is_min_value(input int unsigned width, input logic [63:0] word);
    logic [63:0] mask;
    logic [63:0] min_pat;
    mask    = (64'd1 << width) - 64'd1;
    min_pat = 64'd1 << (width - 1);
    return ((word & mask) == min_pat);
  endfunction

endpackage

// File: rtl/twos_serial_bit_cell.sv
// One step of the copy-until-first-one-then-invert rule, LSB first.
module twos_serial_bit_cell (
  input  logic i_b,
  input  logic i_sign,
  input  logic i_seen_one,
  output logic o_r,
  output logic o_seen_one_next
);

  // Positive words pass through; negative words invert every bit above the first 1.
  assign o_r             = i_b ^ (i_sign & i_seen_one);
  assign o_seen_one_next = i_seen_one | (i_sign & i_b);

endmodule

// File: rtl/twos_to_sign_mag_serial.sv
// Bit-serial two's-complement to sign-magnitude decoder with valid/ready on both sides.
//
// state | meaning
// IDLE  | waiting for a word, in_ready high
// SHIFT | decoding one bit per cycle, LSB first
// DONE  | result held with out_valid high until out_ready
module twos_to_sign_mag_serial
  import twos_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [WIDTH-1:0] out_mag,
  output logic             out_is_min
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_mag;
  logic [CW-1:0]    r_bit_cnt;
  logic             r_sign;
  logic             r_seen_one;
  logic             r_is_min;
  logic             r_in_ready;
  logic             r_out_valid;

  logic w_b;
  logic w_r;
  logic w_seen_one_next;

  assign w_b = r_shift[0];

  twos_serial_bit_cell u_bit_cell (
    .i_b             (w_b),
    .i_sign          (r_sign),
    .i_seen_one      (r_seen_one),
    .o_r             (w_r),
    .o_seen_one_next (w_seen_one_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_mag       <= '0;
      r_bit_cnt   <= '0;
      r_sign      <= 1'b0;
      r_seen_one  <= 1'b0;
      r_is_min    <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_shift    <= in_data;
            r_sign     <= in_data[WIDTH-1];
            r_bit_cnt  <= '0;
            r_seen_one <= 1'b0;
            r_mag      <= '0;
            r_is_min   <= 1'b0;
            r_in_ready <= 1'b0;
            r_state    <= SHIFT;
          end
        end
        SHIFT: begin
          r_shift            <= {1'b0, r_shift[WIDTH-1:1]};
          r_mag[r_bit_cnt]   <= w_r;
          r_seen_one         <= w_seen_one_next;
          r_bit_cnt          <= r_bit_cnt + 1'b1;
          if (r_bit_cnt == LAST_BIT) begin
            // Most-negative iff the only 1 is the sign bit itself.
            r_is_min    <= r_sign & w_b & ~r_seen_one;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_sign   = r_sign;
  assign out_mag    = r_mag;
  assign out_is_min = r_is_min;

endmodule

// File: doc/twos_to_sign_mag_serial.md
# twos_to_sign_mag_serial

Bit-serial decoder that converts a WIDTH-bit two's-complement word into sign-magnitude form. It is the receive-side counterpart of the team's combinational two's-complement negator: values produced or negated upstream are decoded here into a sign flag plus an unsigned magnitude. Decoding is done LSB-first, one bit per cycle, using the copy-until-first-one-then-invert rule. Valid/ready handshakes are used on both the input and the output side.

## Interface

Parameters
- WIDTH, 8: word width in bits; must be ≥ 2.

Ports
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word (high only in IDLE).
- in_data  input  WIDTH  two's-complement operand.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- out_sign  output  1  set to in_data[WIDTH-1] of the accepted word.
- out_mag  output  WIDTH  absolute value, unsigned; the full WIDTH is needed so that the most-negative input is representable.
- out_is_min  output  1  the input was the most-negative value (1 followed by WIDTH-1 zeros).

## Operation

- FSM states are IDLE, SHIFT and DONE. The reset state is IDLE.
- **IDLE**
  - in_ready = 1.
  - When in_valid is high, the block captures in_data into the shift register and in_data[WIDTH-1] into the sign register.
  - It also clears bit_cnt and the seen_one flag, clears out_mag, and moves to SHIFT.
- **SHIFT**
  - in_ready = 0.
  - Each cycle processes bit b = shift register LSB, then shifts the register right by one.
  - If sign = 0: result bit r = b.
  - If sign = 1 and seen_one = 0: r = b, and seen_one is set when b = 1.
  - If sign = 1 and seen_one = 1: r = ~b.
  - r is written into out_mag[bit_cnt], and bit_cnt increments.
  - When bit_cnt = WIDTH-1 has been processed, the FSM moves to DONE.
- **DONE**
  - out_valid = 1.
  - out_sign, out_mag and out_is_min hold stable until out_ready is sampled high. The FSM then returns to IDLE.
- **Most-negative input:** out_mag = 2^(WIDTH-1) and out_is_min = 1. out_is_min = sign & (a 1 was first seen at bit WIDTH-1).
- **Zero:** out_sign = 0, out_mag = 0, out_is_min = 0. A negative zero cannot occur.
- **Busy input:** in_valid is ignored while not in IDLE. The upstream holds its data because in_ready = 0.
- **Reset mid-operation:** the partial result is discarded. The block enters IDLE and all outputs take their reset values on the next cycle.

## Timing

- **Reset values:**
  - in_ready = 1.
  - out_valid = 0.
  - out_sign = 0.
  - out_mag = 0.
  - out_is_min = 0.
  - bit_cnt = 0.
  - seen_one = 0.
- **Accept:** happens at edge E0, where in_valid & in_ready = 1.
- **Processing:** the SHIFT edges are E1 through E_WIDTH.
- **Output:** out_valid is high in the cycle after E_WIDTH. Latency is WIDTH cycles from accept to out_valid.
- **Return to IDLE:** out_valid and out_ready both high at an edge gives IDLE on the next cycle, with in_ready = 1.
- **Throughput:** at best one word per WIDTH+2 cycles. No input/output overlap is allowed.
- **Backpressure:** while out_ready = 0 in DONE, all outputs hold with no change.
- **Output value validity:** out_sign/out_mag/out_is_min are guaranteed valid only while out_valid = 1. They keep their last values after handoff until the next accept clears them.
- **Reset priority:** rst overrides all handshakes in the same cycle.

## Structure

- **Package twos_pkg:**
  - state enum {IDLE, SHIFT, DONE}.
  - constant DEFAULT_WIDTH = 8.
  - function is_min_value(width, word) for checker reuse.
- **Sub-module twos_serial_bit_cell:**
  - Combinational next-bit logic: inputs b, sign, seen_one; outputs r, seen_one_next.
  - Instantiated once inside the top.
- **Top module:** contains the FSM, the WIDTH-bit shift register, the bit counter of width $clog2(WIDTH), and the output registers.

## Test plan

- **Positive value:** in_data = 8'h05 → after 8 cycles out_valid = 1, out_sign = 0, out_mag = 8'h05, out_is_min = 0.
- **Negative value:** in_data = 8'hFB (−5) → out_sign = 1, out_mag = 8'h05. Then in_data = 8'h90 (−112) → out_sign = 1, out_mag = 8'h70.
- **Boundaries:**
  - 8'h80 → out_sign = 1, out_mag = 8'h80, out_is_min = 1.
  - 8'h00 → 0/0/0.
  - 8'h7F → out_sign = 0, out_mag = 8'h7F.
  - 8'hFF → out_sign = 1, out_mag = 8'h01.
- **Backpressure:** hold out_ready = 0 for 5 cycles in DONE → outputs stable and in_ready = 0 throughout. Raise out_ready → in_ready = 1 next cycle.
- **Reset mid-SHIFT:** assert rst on the third SHIFT cycle → next cycle IDLE, in_ready = 1, all outputs 0. Then a new word 8'hF0 → out_mag = 8'h10.
- **Busy input:** pulse in_valid with 8'h01 during SHIFT of 8'hFE → result is out_mag = 8'h02 only, and the 8'h01 is never accepted.
